shift_sequencer: RTL and testbench

Multi-bit shift controller built around the existing single-bit `shift` unit. It accepts one shift command at a time: operand, shift amount and FuncCode. It then steps the `shift` unit once per clock, feeding each result back as the next operand, until the requested amount is reached, and returns the result with a one-cycle `done` pulse. It sits between the ALU issue logic and the `shift` unit, so ALU shift operations support amounts from 0 to 2^AMT_WIDTH−1 without a barrel shifter.

---
 rtl/shift_sequencer.sv | 168 ++++++++++++++++
 tb/tb_shift_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-bit shift controller wrapped around the single-bit
// `shift` unit. One command is accepted at a time. The unit is stepped once
// per clock until the requested amount is reached, then the result is
// presented with a one-cycle `done` pulse.

// shift: single-step shifter. Each evaluation moves A by exactly one bit in
// the direction selected by FuncCode. B takes part in no shift operation.
module shift #(
  parameter int data_width = 16
) (
  input  logic [data_width-1:0] A,
  input  logic [data_width-1:0] B,
  input  logic [3:0]            FuncCode,
  output logic [data_width-1:0] C,
  output logic                  OverflowFlag
);

  // Function codes shared with the ALU decoder (alu_func.v).
  localparam logic [3:0] FUNC_LLS = 4'd8;
  localparam logic [3:0] FUNC_LRS = 4'd9;
  localparam logic [3:0] FUNC_ALS = 4'd10;
  localparam logic [3:0] FUNC_ARS = 4'd11;

  // B is an ALU operand that the shift operations never consume.
  logic b_unused;
  assign b_unused = |B;

  // One-bit shift. The operand is unsigned, so arithmetic right also fills
  // with zero. Any other code produces zero.
  always_comb begin
    C            = '0;
    OverflowFlag = 1'b0;
    case (FuncCode)
      FUNC_LLS, FUNC_ALS: C = {A[data_width-2:0], 1'b0};
      FUNC_LRS, FUNC_ARS: C = {1'b0, A[data_width-1:1]};
      default:            C = '0;
    endcase
  end

endmodule

module shift_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [AMT_WIDTH-1:0]  amount,
  input  logic [3:0]            FuncCode,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] C,
  output logic                  err
);

  localparam logic [3:0] FUNC_LLS = 4'd8;
  localparam logic [3:0] FUNC_LRS = 4'd9;
  localparam logic [3:0] FUNC_ALS = 4'd10;
  localparam logic [3:0] FUNC_ARS = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q,  state_d;
  logic [DATA_WIDTH-1:0] work_q,   work_d;
  logic [AMT_WIDTH-1:0]  cnt_q,    cnt_d;
  logic [3:0]            func_q,   func_d;
  logic [DATA_WIDTH-1:0] c_q,      c_d;
  logic                  err_q,    err_d;

  logic [DATA_WIDTH-1:0] shift_c;
  logic                  shift_ovf_unused;
  logic                  func_legal;

  // The single-bit unit always operates on the working register with the
  // captured function; its overflow flag is never set for shifts.
  shift #(
    .data_width (DATA_WIDTH)
  ) u_shift (
    .A            (work_q),
    .B            ({DATA_WIDTH{1'b0}}),
    .FuncCode     (func_q),
    .C            (shift_c),
    .OverflowFlag (shift_ovf_unused)
  );

  // Only the four shift codes are serviced; anything else is flagged.
  always_comb begin
    func_legal = 1'b0;
    case (FuncCode)
      FUNC_LLS, FUNC_LRS, FUNC_ALS, FUNC_ARS: func_legal = 1'b1;
      default:                                func_legal = 1'b0;
    endcase
  end

  // Next-state logic: accept in IDLE/DONE, count down in SHIFT, and load the
  // result registers only on the transition into DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    c_d     = c_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          work_d = A;
          cnt_d  = amount;
          func_d = FuncCode;
          if (!func_legal) begin
            state_d = S_DONE;
            c_d     = '0;
            err_d   = 1'b1;
          end else if (amount == '0) begin
            state_d = S_DONE;
            c_d     = A;
            err_d   = 1'b0;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_d = shift_c;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == AMT_WIDTH'(1)) begin
          state_d = S_DONE;
          c_d     = shift_c;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset takes priority over any command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      func_q  <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign C    = c_q;
  assign err  = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: the driver pushes the expected
// result, completion cycle and busy length of each accepted command; a
// negedge monitor pops and compares whenever done is seen.
module tb_shift_sequencer;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam logic [3:0] F_LLS = 4'd8;
  localparam logic [3:0] F_LRS = 4'd9;
  localparam logic [3:0] F_ALS = 4'd10;
  localparam logic [3:0] F_ARS = 4'd11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] A;
  logic [AW-1:0] amount;
  logic [3:0]    FuncCode;
  logic          busy, done, err;
  logic [DW-1:0] C;

  shift_sequencer #(.DATA_WIDTH(DW), .AMT_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .amount(amount),
    .FuncCode(FuncCode), .busy(busy), .done(done), .C(C), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] c;
    logic          err;
    int unsigned   done_cyc;
    int unsigned   busy_cnt;
    string         name;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] last_c = '0;
  logic          last_err = 1'b0;
  int unsigned   busy_run = 0;
  int unsigned   next_free = 0;
  bit            mon_en = 1'b0;

  function automatic bit is_legal(logic [3:0] fc);
    return (fc == F_LLS) || (fc == F_LRS) || (fc == F_ALS) || (fc == F_ARS);
  endfunction

  // Reference: N one-bit steps equal one N-bit shift; illegal codes give 0.
  function automatic logic [DW-1:0] ref_result(logic [DW-1:0] a, int amt, logic [3:0] fc);
    logic [DW-1:0] r;
    case (fc)
      F_LLS, F_ALS: r = a << amt;
      F_LRS, F_ARS: r = a >> amt;
      default:      r = '0;
    endcase
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: compare on every done pulse, and check that C/err hold
  // their last reported values in every other cycle.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_C"},     32'(C),        32'(e.c));
          check({e.name, "_err"},   32'(err),      32'(e.err));
          check({e.name, "_cycle"}, cyc,           e.done_cyc);
          check({e.name, "_busy"},  busy_run,      e.busy_cnt);
          $display("[TB] %s C=0x%04h err=%0d cycle=%0d busy=%0d", e.name, C, err, cyc, busy_run);
          last_c   = e.c;
          last_err = e.err;
        end
        busy_run = 0;
      end else begin
        check("C_stable",   32'(C),   32'(last_c));
        check("err_stable", 32'(err), 32'(last_err));
      end
    end
  end

  // Issue one command once the model says the DUT can accept it. While
  // waiting, optionally hold start high with junk that must be dropped.
  task automatic send(input logic [DW-1:0] a, input logic [AW-1:0] amt,
                      input logic [3:0] fc, input bit junk, input string nm);
    int unsigned k, lat;
    bit legal;
    while (cyc < next_free) begin
      start    = junk;
      A        = DW'($urandom);
      amount   = AW'($urandom);
      FuncCode = 4'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b1; A = a; amount = amt; FuncCode = fc;
    @(posedge clk); #1;
    k     = cyc;
    legal = is_legal(fc);
    lat   = (!legal || amt == 0) ? 0 : int'(amt);
    sb.push_back('{ref_result(a, int'(amt), fc), !legal, k + lat, lat, nm});
    next_free = k + lat;
    start    = 1'b0;
    A        = DW'($urandom);
    amount   = AW'($urandom);
    FuncCode = 4'($urandom);
  endtask

  task automatic do_reset(input int n, input bit start_hi);
    reset = 1'b1;
    start = start_hi;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    sb.delete();
    last_c    = '0;
    last_err  = 1'b0;
    busy_run  = 0;
    next_free = cyc;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_C",    32'(C),    32'd0);
    check("rst_err",  32'(err),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] codes [4];
    codes = '{F_LLS, F_LRS, F_ALS, F_ARS};
    reset = 1'b1; start = 1'b1; A = 16'hFFFF; amount = 4'd3; FuncCode = F_LLS;
    @(posedge clk); #1;
    do_reset(2, 1'b1);
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    send(16'h0001, 4'd4,  F_LLS, 1'b0, "lls4");
    send(16'hBEEF, 4'd0,  F_LRS, 1'b0, "lrs0");
    send(16'h8000, 4'd15, F_ARS, 1'b0, "ars15");
    send(16'h1234, 4'd7,  4'd0,  1'b0, "illegal7");
    send(16'h00F0, 4'd1,  F_LLS, 1'b0, "legal_after_illegal");
    send(16'h0003, 4'd2,  F_ALS, 1'b1, "b2b_als2");
    send(16'hF000, 4'd3,  F_LRS, 1'b1, "b2b_lrs3");
    send(16'h7FFF, 4'd15, F_LLS, 1'b0, "lls15");

    // Abort a long command in its third SHIFT cycle.
    send(16'h5555, 4'd10, F_LLS, 1'b0, "aborted");
    repeat (2) @(posedge clk);
    #1;
    do_reset(1, 1'b0);
    send(16'h0101, 4'd3, F_LRS, 1'b0, "after_reset");

    for (int i = 0; i < 40; i++) begin
      logic [3:0] fc;
      if ($urandom_range(0, 4) == 0) fc = 4'($urandom);
      else                           fc = codes[$urandom_range(0, 3)];
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(DW'($urandom), AW'($urandom_range(0, 15)), fc,
           1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    start = 1'b0;
    while (cyc < next_free + 3) begin
      @(posedge clk); #1;
    end
    check("drain_pending", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
